btn_conditioner: RTL and testbench

- Input-side front end for the whack-a-mole game. Sits between the raw button pins and the game FSM.
- Synchronises and debounces N_BTN asynchronous button inputs.
- Emits one-cycle press/release pulses, masked per button by the FSM's lockout vector.
- Provides a registered held-level vector and a lowest-index press encoder, so the FSM consumes clean single events.

---
 rtl/btn_conditioner.sv | 85 ++++++++
 tb/tb_btn_conditioner.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Synchronises, debounces and edge-detects N_BTN raw buttons; held level, press/release pulses, lowest-index press encoder.
// Latency: a clean pin edge reaches held_o/press_o/release_o DB_CYCLES+2 clocks after the first sampling edge; encoder is combinational from press.
// Backpressure: none; pulses last one cycle, and presses masked by lockout_i on the accepting edge are dropped, not deferred.
module btn_conditioner #(
    parameter int N_BTN     = 8,
    parameter int DB_WIDTH  = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_BTN-1:0]                       btn_raw_i,
    input  logic [N_BTN-1:0]                       lockout_i,
    output logic [N_BTN-1:0]                       held_o,
    output logic [N_BTN-1:0]                       press_o,
    output logic [N_BTN-1:0]                       release_o,
    output logic                                   press_valid_o,
    output logic [((N_BTN > 1) ? $clog2(N_BTN) : 1)-1:0] press_idx_o,
    output logic                                   press_multi_o
);
    localparam int IDX_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam logic [DB_WIDTH-1:0] CNT_LAST = DB_WIDTH'(DB_CYCLES - 1);

    logic [N_BTN-1:0]    s1_q, s2_q, db_q, db_d;
    logic [N_BTN-1:0]    press_q, press_d, release_q, release_d;
    logic [DB_WIDTH-1:0] cnt_q [N_BTN];
    logic [DB_WIDTH-1:0] cnt_d [N_BTN];
    logic [IDX_W-1:0]    idx;

    // Any cycle where the synchronised pin agrees with db restarts the run.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + DB_WIDTH'(1);
            end
        end
        press_d   = db_d & ~db_q & ~lockout_i;
        release_d = ~db_d & db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= btn_raw_i;
            s2_q      <= s1_q;
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Scan downwards so the lowest set index wins.
    always_comb begin
        idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign held_o        = db_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign press_valid_o = |press_q;
    assign press_idx_o   = idx;
    assign press_multi_o = |(press_q & (press_q - N_BTN'(1)));
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DB_CYCLES=4: directed vector table, hand-written corner sequences,
// and randomised bouncing stimulus against a sliding-window reference model.
module tb_btn_conditioner;
    localparam int N  = 8;
    localparam int DB = 4;

    logic         clk, rst_n;
    logic [N-1:0] btn_raw, lockout;
    logic [N-1:0] held, press, rel;
    logic         pvalid, pmulti;
    logic [2:0]   pidx;

    btn_conditioner #(.N_BTN(N), .DB_WIDTH(16), .DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_raw_i    (btn_raw),
        .lockout_i    (lockout),
        .held_o       (held),
        .press_o      (press),
        .release_o    (rel),
        .press_valid_o(pvalid),
        .press_idx_o  (pidx),
        .press_multi_o(pmulti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: pin seen two clocks late; level flips once the last DB samples all disagree.
    logic [N-1:0]  ms1, ms2, mheld, mpress, mrel;
    logic [DB-1:0] win [N];

    task automatic model_reset();
        ms1 = '0; ms2 = '0; mheld = '0; mpress = '0; mrel = '0;
        for (int i = 0; i < N; i++) win[i] = '0;
    endtask

    task automatic model_edge(input logic [N-1:0] raw, input logic [N-1:0] lock);
        logic [N-1:0] nh;
        nh = mheld;
        for (int i = 0; i < N; i++) begin
            win[i] = {win[i][DB-2:0], ms2[i]};
            if (win[i] == {DB{~mheld[i]}}) nh[i] = ~mheld[i];
        end
        mpress = nh & ~mheld & ~lock;
        mrel   = ~nh & mheld;
        mheld  = nh;
        ms2    = ms1;
        ms1    = raw;
    endtask

    function automatic logic [4:0] enc(input logic [N-1:0] p);
        logic [2:0] ix;
        ix = 3'd0;
        for (int i = 0; i < N; i++) begin
            if (p[i]) begin
                ix = 3'(i);
                break;
            end
        end
        return {(p != 0), ix, ($countones(p) > 1)};
    endfunction

    task automatic step(input logic [N-1:0] raw, input logic [N-1:0] lock);
        btn_raw = raw;
        lockout = lock;
        @(posedge clk);
        model_edge(raw, lock);
        @(negedge clk);
        chk("model_levels", {8'h0, held, press, rel}, {8'h0, mheld, mpress, mrel});
        chk("model_enc", {27'h0, pvalid, pidx, pmulti}, {27'h0, enc(mpress)});
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {7'h0, held, press, rel, pvalid, pidx, pmulti},
               {7'h0, 8'h0, 8'h0, 8'h0, 1'b0, 3'd0, 1'b0});
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] lock;
        logic [N-1:0] held;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } vec_t;

    vec_t tbl [8];
    logic [N-1:0] seen, r;
    int cnt;

    initial begin
        rst_n = 1'b1; btn_raw = '0; lockout = '0;
        model_reset();
        tbl[0] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[1] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[2] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[3] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{8'h08, 8'h00, 8'h08, 8'h08, 8'h00};
        tbl[6] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h00};
        tbl[7] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h00};

        @(negedge clk);
        do_reset();

        // btn 3 rise: accepted on the 6th sampling edge
        for (int k = 0; k < 8; k++) begin
            step(tbl[k].raw, tbl[k].lock);
            chk($sformatf("tbl_%0d", k), {8'h0, held, press, rel}, {8'h0, tbl[k].held, tbl[k].press, tbl[k].rel});
            if (tbl[k].press != 0)
                chk("tbl_enc", {27'h0, pvalid, pidx, pmulti}, {27'h0, 1'b1, 3'd3, 1'b0});
        end

        // btn 5 high for only 3 cycles
        seen = '0;
        for (int k = 0; k < 11; k++) begin
            step((k < 3) ? 8'h28 : 8'h08, 8'h00);
            seen |= press | rel;
        end
        chk("short_pulse_held", {24'h0, held}, 32'h08);
        chk("short_pulse_evts", {24'h0, seen}, 32'h0);

        // btn 2 under lockout, lockout lifted while held, then released
        seen = '0;
        for (int k = 0; k < 8; k++) begin
            step(8'h0C, 8'h04);
            seen |= press;
        end
        chk("lock_held", {24'h0, held}, 32'h0C);
        for (int k = 0; k < 4; k++) begin
            step(8'h0C, 8'h00);
            seen |= press;
        end
        chk("lock_no_press", {24'h0, seen}, 32'h0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(8'h08, 8'h00);
            if (rel == 8'h04) cnt++;
        end
        chk("lock_release_once", cnt, 1);

        // btn 1 and btn 6 together
        for (int k = 1; k <= 7; k++) begin
            step(8'h4A, 8'h00);
            if (k == 6) begin
                chk("simul_press", {24'h0, press}, 32'h42);
                chk("simul_enc", {27'h0, pvalid, pidx, pmulti}, {27'h0, 1'b1, 3'd1, 1'b1});
            end
            if (k == 7) chk("simul_one_cycle", {24'h0, press}, 32'h0);
        end
        for (int k = 0; k < 8; k++) step(8'h00, 8'h00);
        chk("all_released", {24'h0, held}, 32'h0);

        // reset while btn 0 held, then re-debounce
        for (int k = 0; k < 8; k++) step(8'h01, 8'h00);
        chk("pre_reset_held", {24'h0, held}, 32'h01);
        do_reset();
        cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            step(8'h01, 8'h00);
            if (press != 0) cnt++;
            if (k == 6) chk("post_reset_press", {24'h0, press}, 32'h01);
        end
        chk("post_reset_once", cnt, 1);

        // bounce on btn 7: 1,1,1,0,1,1,1,1 then held
        for (int k = 1; k <= 11; k++) begin
            step((k == 4) ? 8'h01 : 8'h81, 8'h00);
            if (k == 9)  chk("bounce_not_yet", {31'h0, held[7]}, 32'h0);
            if (k == 10) chk("bounce_accept", {24'h0, held, press}, {16'h0, 8'h81, 8'h80});
        end

        // randomised bouncing with random lockout
        r = 8'h81;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, (c < 1500) ? 2 : 11) == 0) r[i] = ~r[i];
            if (c == 1500) do_reset();
            step(r, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
